time_entry: RTL and testbench

TIME_ENTRY -- requirements
Module: time_entry

---
 rtl/timer_pkg.sv | 19 +
 rtl/bcd2_to_bin.sv | 10 +
 rtl/time_entry.sv | 115 +++++++++++
 tb/tb_time_entry.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the keypad time-entry path of the countdown timer.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CONVERT = 3'd2,
    LOAD    = 3'd3,
    ERROR   = 3'd4
  } state_e;

  localparam logic [6:0] SEC_PER_MIN  = 7'd60;
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam int         MAX_SECONDS  = 5999;
  // Width that holds any legal MM:SS total in seconds.
  localparam int         TV_W         = $clog2(MAX_SECONDS + 1);

endpackage

// File: rtl/bcd2_to_bin.sv
// Two BCD digits (tens, units) to binary 0..99; purely combinational.
module bcd2_to_bin (
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic [6:0] bin
);

  assign bin = ({3'b000, tens} * 7'd10) + {3'b000, units};

endmodule

// File: rtl/time_entry.sv
// Keypad MM:SS entry: buffers 4 BCD digits, validates, converts to seconds and pulses load.
// enter -> load two edges later; digits/enter accepted only while ready (IDLE/ENTRY).
module time_entry #(
  parameter int NDIG  = 4,
  parameter int SEC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             enter,
  input  logic             clear,
  output logic             ready,
  output logic             load,
  output logic [SEC_W-1:0] time_val,
  output logic             err,
  output logic [2:0]       digit_cnt
);
  import timer_pkg::*;

  state_e                 state_q, state_d;
  logic [NDIG-1:0][3:0]   buf_q, buf_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [SEC_W-1:0]       tv_q, tv_d;

  logic [6:0]             min_bin, sec_bin;
  logic [TV_W-1:0]        secs_total;
  logic                   digit_bad, digit_ok;

  bcd2_to_bin u_min (.tens(buf_q[3]), .units(buf_q[2]), .bin(min_bin));
  bcd2_to_bin u_sec (.tens(buf_q[1]), .units(buf_q[0]), .bin(sec_bin));

  assign secs_total = (TV_W'(min_bin) * TV_W'(SEC_PER_MIN)) + TV_W'(sec_bin);

  // An invalid digit is an error even when the buffer is already full.
  assign digit_bad = digit_valid && (digit > BCD_MAX);
  assign digit_ok  = digit_valid && (digit <= BCD_MAX) && (cnt_q < 3'(NDIG));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tv_q    <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tv_q    <= tv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tv_d    = tv_q;

    if (clear) begin
      // Also taken in LOAD: the pulse for this cycle is already on the output.
      state_d = IDLE;
      buf_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ENTRY: begin
          if (enter) begin
            if (state_q == ENTRY) begin
              if (buf_q[1] > SEC_TENS_MAX) begin
                state_d = ERROR;
                err_d   = 1'b1;
              end else begin
                state_d = CONVERT;
              end
            end
          end else if (digit_bad) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else if (digit_ok) begin
            buf_d   = {buf_q[NDIG-2:0], digit};
            cnt_d   = cnt_q + 3'd1;
            state_d = ENTRY;
          end
        end
        CONVERT: begin
          tv_d    = SEC_W'(secs_total);
          state_d = LOAD;
        end
        LOAD: begin
          state_d = IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign ready     = (state_q == IDLE) || (state_q == ENTRY);
  assign load      = (state_q == LOAD);
  assign time_val  = tv_q;
  assign err       = err_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_time_entry.sv
// Randomized + directed bench for time_entry with a digit-list reference model and load scoreboard.
module tb_time_entry;

  logic        clk;
  logic        rst;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        enter;
  logic        clear;
  logic        ready;
  logic        load;
  logic [15:0] time_val;
  logic        err;
  logic [2:0]  digit_cnt;

  time_entry #(.NDIG(4), .SEC_W(16)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .clear(clear), .ready(ready), .load(load),
    .time_val(time_val), .err(err), .digit_cnt(digit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int cyc; int tv; } exp_t;
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int neg_cnt = 0;
  bit armed = 0;

  // Reference model: the entry as a list of typed digits plus a load-pending phase.
  int mdig[$];
  bit merr;
  int mph;      // 0: accepting/idle, 1: conversion pending, 2: load cycle
  int mtv;
  int mpend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int entry_secs(input int sz, input int d0, input int d1,
                                    input int d2, input int d3, output int stens);
    int p[4];
    int src[4];
    src[0] = d0; src[1] = d1; src[2] = d2; src[3] = d3;
    for (int i = 0; i < 4; i++) p[i] = 0;
    for (int i = 0; i < sz; i++) p[4 - sz + i] = src[i];
    stens = p[2];
    return (p[0] * 10 + p[1]) * 60 + p[2] * 10 + p[3];
  endfunction

  task automatic model_update(input bit dv, input int d, input bit en, input bit clr, input bit r);
    int s, st;
    int q[4];
    if (r) begin
      if (mph == 1 && exp_q.size() > 0) void'(exp_q.pop_back());
      mdig = {}; merr = 0; mph = 0; mtv = 0;
      armed = 1;
    end else if (mph == 2) begin
      mdig = {}; mph = 0;
      if (clr) merr = 0;
    end else if (clr) begin
      if (mph == 1 && exp_q.size() > 0) void'(exp_q.pop_back());
      mdig = {}; merr = 0; mph = 0;
    end else if (mph == 1) begin
      mtv = mpend; mph = 2;
    end else if (merr) begin
      // locked until clear/reset
    end else if (en) begin
      if (mdig.size() > 0) begin
        for (int i = 0; i < 4; i++) q[i] = (i < mdig.size()) ? mdig[i] : 0;
        s = entry_secs(mdig.size(), q[0], q[1], q[2], q[3], st);
        if (st > 5) merr = 1;
        else begin
          mph = 1;
          mpend = s;
          exp_q.push_back('{cyc: neg_cnt + 2, tv: s});
        end
      end
    end else if (dv) begin
      if (d > 9) merr = 1;
      else if (mdig.size() < 4) mdig.push_back(d);
    end
  endtask

  task automatic check_status();
    chk("ready", ready, (!merr && mph == 0) ? 1 : 0);
    chk("err", err, merr);
    chk("digit_cnt", digit_cnt, mdig.size());
    chk("time_val_held", time_val, mtv);
  endtask

  task automatic cycle(input bit dv, input int d, input bit en, input bit clr, input bit r);
    digit_valid = dv;
    digit       = 4'(d);
    enter       = en;
    clear       = clr;
    rst         = r;
    @(posedge clk);
    model_update(dv, d, en, clr, r);
    @(negedge clk);
    check_status();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic dig4(input int a, input int b, input int c, input int e);
    cycle(1, a, 0, 0, 0);
    cycle(1, b, 0, 0, 0);
    cycle(1, c, 0, 0, 0);
    cycle(1, e, 0, 0, 0);
  endtask

  // Scoreboard monitor: load must appear exactly when an entry is due, with its seconds.
  always @(negedge clk) begin
    exp_t e;
    bit due;
    neg_cnt++;
    if (armed) begin
      due = (exp_q.size() > 0) && (exp_q[0].cyc == neg_cnt);
      chk("load_pulse", load, due);
      if (due) begin
        e = exp_q.pop_front();
        if (load === 1'b1) chk("time_val_at_load", time_val, e.tv);
      end
    end
  end

  initial begin
    int r, d;
    bit dv, en, cl, rs;
    rst = 1'b0; digit_valid = 1'b0; digit = 4'd0; enter = 1'b0; clear = 1'b0;
    merr = 0; mph = 0; mtv = 0; mpend = 0;
    @(negedge clk);
    cycle(0, 0, 0, 0, 1);

    dig4(0, 1, 3, 0); cycle(0, 0, 1, 0, 0); idle(3);               // 90 s
    dig4(9, 9, 5, 9); cycle(1, 7, 0, 0, 0); cycle(0, 0, 1, 0, 0); idle(3); // 5999 s
    cycle(1, 1, 0, 0, 0); cycle(1, 2, 0, 0, 0); cycle(1, 5, 0, 0, 0);
    cycle(0, 0, 1, 0, 0); idle(3);                                  // 85 s
    dig4(0, 0, 7, 5); cycle(0, 0, 1, 0, 0); idle(2);                // seconds tens > 5
    cycle(1, 3, 1, 0, 0); idle(1); cycle(0, 0, 0, 1, 0);
    cycle(1, 10, 0, 0, 0); idle(1); cycle(0, 0, 0, 1, 0);           // invalid digit
    dig4(0, 0, 1, 0); cycle(0, 0, 1, 0, 0); idle(3);                // 10 s
    cycle(0, 0, 1, 0, 0); idle(2);                                  // enter with empty buffer
    dig4(0, 0, 3, 0); cycle(0, 0, 1, 1, 0); idle(3);                // clear beats enter
    dig4(0, 0, 0, 5); cycle(0, 0, 1, 0, 0); idle(1); cycle(0, 0, 0, 1, 0); idle(2); // clear in LOAD
    dig4(0, 1, 0, 0); cycle(1, 4, 1, 0, 0); cycle(0, 0, 0, 0, 1); idle(3); // reset in CONVERT
    dig4(0, 2, 0, 0); cycle(0, 0, 1, 0, 0); cycle(0, 0, 0, 1, 0); idle(3); // clear in CONVERT

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      dv = 0; en = 0; cl = 0; rs = 0;
      if (r < 2) rs = 1;
      else if (r < 5 || (merr && r < 35)) cl = 1;
      else if (r < 20) begin
        en = 1;
        if ($urandom_range(0, 3) == 0) dv = 1;
      end else if (r < 85) dv = 1;
      d = ($urandom_range(0, 11) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      cycle(dv, d, en, cl, rs);
    end
    idle(4);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
